// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: producer-side request/busy/done handshake plus the TX line.
// master = byte producer, slave = transmitter.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic [2:0]        baud_set;
    logic              send_en;
    logic              uart_tx;
    logic              tx_busy;
    logic              uart_tx_done;

    modport master (
        output data_in, baud_set, send_en,
        input  uart_tx, tx_busy, uart_tx_done
    );

    modport slave (
        input  data_in, baud_set, send_en,
        output uart_tx, tx_busy, uart_tx_done
    );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter, start + LSB-first data + [parity] + stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd chosen by PARITY_ODD).
module uart_tx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input logic            clk,
    input logic            rst_n,
    uart_tx_param_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_FREQ / 300 + 1);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // Divisors are stored as DIV-1 so the compare needs no subtractor.
    function automatic logic [CNT_W-1:0] divMinusOne(input int baud);
        return CNT_W'((CLK_FREQ + baud / 2) / baud - 1);
    endfunction

    localparam logic [CNT_W-1:0] DIV_M1 [8] = '{
        divMinusOne(300),   divMinusOne(1200),  divMinusOne(2400),  divMinusOne(4800),
        divMinusOne(9600),  divMinusOne(19200), divMinusOne(57600), divMinusOne(115200)
    };

    if (DATA_W < 5 || DATA_W > 9) begin : g_badDataW
        $error("uart_tx_param: DATA_W must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStopBits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_badParityOdd
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  bit_q, bit_d;
    logic              stop_q, stop_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              lastTick;

    assign lastTick         = (cnt_q == div_q);
    assign bus.uart_tx      = tx_q;
    assign bus.tx_busy      = (state_q != IDLE);
    assign bus.uart_tx_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx_d is decoded from the next state so the line is registered with no extra lag.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        data_d  = data_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        cnt_d   = (state_q == IDLE || lastTick) ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.send_en) begin
                    state_d = START;
                    data_d  = bus.data_in;
                    div_d   = DIV_M1[bus.baud_set];
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            START: begin
                if (lastTick) state_d = DATA;
            end
            DATA: begin
                if (lastTick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (lastTick) state_d = STOP;
            end
`endif
            STOP: begin
                if (lastTick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = (^data_d) ^ 1'(PARITY_ODD);
`endif
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param at a reduced clock rate.
// Expected frames are queued at request time and checked bit-by-bit off the TX line.
module tb_uart_tx_param;
    localparam int CLK_FREQ   = 260_000;
    localparam int STOP_BITS  = 2;
    localparam int PARITY_ODD = 1;
    // (CLK_FREQ + baud/2) / baud for baud_set 0..7 at 260 kHz, worked by hand
    localparam int DIV_TAB [8] = '{867, 217, 108, 54, 27, 14, 5, 2};
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
    } expFrame_t;

    logic      clk;
    logic      rst_n;
    expFrame_t expQ[$];
    int        checkCount     = 0;
    int        failCount      = 0;
    int        doneSeen       = 0;
    int        framesExpected = 0;

    uart_tx_param_if #(.DATA_W(8)) bus ();

    uart_tx_param #(
        .CLK_FREQ  (CLK_FREQ),
        .DATA_W    (8),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] b, input logic s);
        bus.data_in  = d;
        bus.baud_set = b;
        bus.send_en  = s;
    endtask

    function automatic int frameCycles(input int div);
        return (1 + 8 + PAR_BITS + STOP_BITS) * div;
    endfunction

    // Drives one request from idle; inputs are scrambled right after acceptance.
    task automatic sendFrame(input logic [7:0] d, input logic [2:0] b);
        @(posedge clk); #2;
        applyStimulus(d, b, 1'b1);
        expQ.push_back('{data: d, div: DIV_TAB[b]});
        framesExpected++;
        @(posedge clk); #2;
        applyStimulus(~d, b ^ 3'd1, 1'b0);
        checkOutput("acceptLatency", int'({bus.tx_busy, bus.uart_tx}), 2);
    endtask

    task automatic waitDone(input int maxCycles, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (bus.uart_tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(tag, 0, 1);
    endtask

    // Called at the first negedge of a frame; walks every bit segment cycle by cycle.
    task automatic checkFrame(input expFrame_t e);
        logic segVal [12];
        int   segLen [12];
        int   n = 0;
        segVal[n] = 1'b0; segLen[n] = e.div; n++;
        for (int i = 0; i < 8; i++) begin
            segVal[n] = e.data[i]; segLen[n] = e.div; n++;
        end
        if (PAR_BITS == 1) begin
            segVal[n] = (^e.data) ^ 1'(PARITY_ODD); segLen[n] = e.div; n++;
        end
        segVal[n] = 1'b1; segLen[n] = STOP_BITS * e.div; n++;

        for (int s = 0; s < n; s++) begin
            int bad = 0;
            for (int c = 0; c < segLen[s]; c++) begin
                if (!(s == 0 && c == 0)) @(negedge clk);
                if (!rst_n) return;
                if (bus.uart_tx !== segVal[s] || bus.tx_busy !== 1'b1 || bus.uart_tx_done !== 1'b0)
                    bad++;
            end
            checkOutput($sformatf("seg%0d_data%02h", s, e.data), bad, 0);
        end
        @(negedge clk);
        if (!rst_n) return;
        checkOutput($sformatf("doneCycle_data%02h", e.data),
                    int'({bus.uart_tx_done, bus.tx_busy, bus.uart_tx}), 5);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.tx_busy === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", 1, 0);
                    for (int i = 0; i < 20_000 && bus.tx_busy === 1'b1; i++) @(negedge clk);
                end else begin
                    checkFrame(expQ.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.uart_tx_done === 1'b1) doneSeen++;
    end

    initial begin : stimulus
        rst_n = 1'b0;
        applyStimulus(8'h00, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("resetState", int'({bus.uart_tx, bus.tx_busy, bus.uart_tx_done}), 4);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] basic frames");
        sendFrame(8'h55, 3'd7);
        waitDone(frameCycles(DIV_TAB[7]) + 20, "timeoutBasic7");
        sendFrame(8'h55, 3'd5);
        waitDone(frameCycles(DIV_TAB[5]) + 20, "timeoutBasic5");
        sendFrame(8'h07, 3'd4);
        waitDone(frameCycles(DIV_TAB[4]) + 20, "timeoutParity");

        $display("[TB] ignored request mid-frame");
        sendFrame(8'h96, 3'd5);
        repeat (40) @(posedge clk);
        #2;
        applyStimulus(8'hFF, 3'd7, 1'b1);
        @(posedge clk); #2;
        applyStimulus(8'hFF, 3'd7, 1'b0);
        waitDone(frameCycles(DIV_TAB[5]) + 20, "timeoutIgnored");
        repeat (40) @(posedge clk);

        $display("[TB] back-to-back frames");
        @(posedge clk); #2;
        applyStimulus(8'hA5, 3'd6, 1'b1);
        expQ.push_back('{data: 8'hA5, div: DIV_TAB[6]});
        @(posedge clk); #2;
        checkOutput("b2bFirstAccept", int'({bus.tx_busy, bus.uart_tx}), 2);
        applyStimulus(8'h3C, 3'd6, 1'b1);
        expQ.push_back('{data: 8'h3C, div: DIV_TAB[6]});
        framesExpected += 2;
        waitDone(frameCycles(DIV_TAB[6]) + 20, "timeoutB2bFirst");
        @(posedge clk); #2;
        checkOutput("b2bStart", int'({bus.tx_busy, bus.uart_tx}), 2);
        applyStimulus(8'h00, 3'd6, 1'b0);
        waitDone(frameCycles(DIV_TAB[6]) + 20, "timeoutB2bSecond");
        repeat (10) @(posedge clk);

        $display("[TB] reset during data bit 3");
        sendFrame(8'h5A, 3'd6);
        framesExpected--;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetTx", int'(bus.uart_tx), 1);
        checkOutput("midResetBusy", int'(bus.tx_busy), 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("midResetDone", int'(bus.uart_tx_done), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        sendFrame(8'hC3, 3'd6);
        waitDone(frameCycles(DIV_TAB[6]) + 20, "timeoutAfterReset");

        $display("[TB] slower rates");
        for (int b = 3; b >= 0; b--) begin
            sendFrame(8'($urandom_range(0, 255)), 3'(b));
            waitDone(frameCycles(DIV_TAB[b]) + 20, $sformatf("timeoutBaud%0d", b));
        end

        repeat (20) @(posedge clk);
        #2;
        checkOutput("doneCount", doneSeen, framesExpected);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter that serialises one DATA_W-bit word per request as start, data LSB-first, optional parity and 1 or 2 stop bits. Baud divisors are derived from CLK_FREQ at elaboration and selected at run time by an 8-entry table. It sits between a byte producer (test logic, FIFO or command engine) and the FPGA TX pin. It uses a request/busy/done handshake so that back-to-back frames need no idle gap.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- DATA_W, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- data_in  input  DATA_W  word to send, sampled on an accepted request
- baud_set  input  3  baud select, sampled on an accepted request
- send_en  input  1  transmit request, level, sampled every clk
- uart_tx  output  1  serial line, registered, idles high
- tx_busy  output  1  high while a frame is in progress
- uart_tx_done  output  1  one-cycle pulse at end of frame

## Operation
- Baud table, indexed by baud_set 0..7: 300, 1200, 2400, 4800, 9600, 19200, 57600, 115200.
- DIV = (CLK_FREQ + baud/2) / baud, integer arithmetic at elaboration. At 50 MHz, 115200 gives DIV = 434 and 300 gives DIV = 166667.
- Divider counter width = $clog2(CLK_FREQ/300 + 1). The counter runs 0..DIV-1 only while busy and is cleared in IDLE.
- A request is accepted when send_en = 1 and tx_busy = 0. On acceptance:
  - data_in goes into the shift register and baud_set goes into the divisor register.
  - Later changes to either input do not affect the frame in flight.
- send_en while tx_busy = 1 is ignored. It is not queued.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: uart_tx = 1. An accepted request goes to START.
  - START: uart_tx = 0 for DIV cycles.
  - DATA: bit_idx runs 0..DATA_W-1 and uart_tx = data[bit_idx], each bit for DIV cycles. After bit DATA_W-1 the FSM goes to PARITY if compiled in, otherwise to STOP.
  - PARITY: uart_tx = ^data XOR PARITY_ODD for DIV cycles.
  - STOP: uart_tx = 1 for STOP_BITS*DIV cycles, then IDLE.
- Each state exits when the divider reaches DIV-1. Bit and stop counters advance on that same cycle.
- Frame length = (1 + DATA_W + P + STOP_BITS) * DIV cycles, where P is 1 with parity and 0 without.

## Timing
- Reset values: uart_tx = 1, tx_busy = 0, uart_tx_done = 0. All internal counters and the FSM clear to IDLE.
- Reset asserted mid-frame: uart_tx returns to 1 and tx_busy to 0 asynchronously. No done pulse is emitted.
- Request sampled at edge N: tx_busy = 1 and uart_tx = 0 after edge N. Latency is one cycle.
- End of frame: after the final stop-bit cycle, tx_busy drops and uart_tx_done = 1 for exactly one cycle.
- send_en = 1 during the done cycle is accepted. The next start bit begins on the following edge, so there is no idle gap beyond the stop bits.
- If send_en is held high continuously, frames repeat back-to-back. data_in is re-sampled at each acceptance.
- Every bit holds exactly DIV cycles. There is no cumulative drift apart from the divisor rounding.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present and one parity bit is inserted between the data bits and the stop bits, even or odd per PARITY_ODD.
- UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent, DATA goes directly to STOP, and PARITY_ODD has no effect.

## Test plan
- Basic frame: CLK_FREQ = 50M, DATA_W = 8, STOP_BITS = 1, no parity, baud_set = 7, data_in = 0x55 -> uart_tx carries 0,1,0,1,0,1,0,1,0,1 with each bit exactly 434 cycles. uart_tx_done pulses once at cycle 4340 after acceptance.
- Parity frame: UART_TX_PARITY_EN defined, PARITY_ODD = 0, STOP_BITS = 2, data_in = 0x07 -> parity bit = 1, stop high for 868 cycles, frame = 12 × 434 cycles. Repeat with PARITY_ODD = 1 -> parity bit = 0.
- Ignored request: pulse send_en mid-frame with a different data_in and baud_set -> the current frame is unchanged and no extra frame follows.
- Back-to-back: hold send_en = 1 with data_in 0xA5 then 0x3C -> second start bit falls on the cycle after the done pulse, with no extra idle cycle.
- Reset mid-frame: assert rst_n = 0 during data bit 3 -> uart_tx = 1 and tx_busy = 0 immediately, no done pulse. A new request after release sends a clean frame.
- Slow rate: baud_set = 0 -> each bit is 166667 cycles with no counter overflow. Also check baud_set = 4 -> 5208 cycles per bit.
